// File: rtl/key_avalon_slave_if.sv
// Avalon-MM slave bus bundle for the push-button controller.
// The master modport drives the strobes; the slave modport returns readdata.
interface key_avalon_slave_if;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata
  );
endinterface

// File: rtl/key_avalon_slave.sv
// Debounced push-button controller with an Avalon-MM register window.
// Registers: DATA, interrupt MASK, press-EDGE latch (W1C); irq = |(EDGE & MASK).
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CW              = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic deb
);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          pressed;

  // Synchronizer idles at 1 so a released key reads as released out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], key_n};
  end

  assign pressed = ~sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      deb <= 1'b0;
    end else if (pressed == deb) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      deb <= pressed;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

module key_avalon_slave #(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  input  logic [WIDTH-1:0]   key_n,
  key_avalon_slave_if.slave  avs,
  output logic               irq
);
  logic [WIDTH-1:0] deb, deb_q, mask_q, edge_q, edge_clr, edge_set;
  logic [31:0]      rd_mux;
  logic             wr_mask, wr_edge;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane [WIDTH-1:0] (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .key_n (key_n),
    .deb   (deb)
  );

  assign wr_mask  = avs.avs_write && (avs.avs_address == 2'd1);
  assign wr_edge  = avs.avs_write && (avs.avs_address == 2'd2);
  assign edge_clr = wr_edge ? avs.avs_writedata[WIDTH-1:0] : '0;
  assign edge_set = deb & ~deb_q;

  wire unused_wdata = &{1'b0, avs.avs_writedata[31:WIDTH]};

  always_comb begin
    rd_mux = '0;
    case (avs.avs_address)
      2'd0:    rd_mux[WIDTH-1:0] = deb;
      2'd1:    rd_mux[WIDTH-1:0] = mask_q;
      2'd2:    rd_mux[WIDTH-1:0] = edge_q;
      default: rd_mux = '0;
    endcase
  end

  // Set is ORed after the clear so a coincident press survives a W1C.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      deb_q  <= '0;
      mask_q <= '0;
      edge_q <= '0;
    end else begin
      deb_q  <= deb;
      edge_q <= (edge_q & ~edge_clr) | edge_set;
      if (wr_mask) mask_q <= avs.avs_writedata[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)    avs.avs_readdata <= '0;
    else if (avs.avs_read) avs.avs_readdata <= rd_mux;
  end

  assign irq = |(edge_q & mask_q);
endmodule

// File: tb/tb_key_avalon_slave.sv
// Randomized + directed bench for key_avalon_slave against a window-based reference model.
module tb_key_avalon_slave;
  localparam int W  = 3;
  localparam int DB = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] key_n = '1;
  logic         irq;
  logic         chk_en = 1'b0;
  int           n_tot = 0;
  int           n_bad = 0;

  key_avalon_slave_if bus ();

  key_avalon_slave #(.WIDTH(W), .DEBOUNCE_CYCLES(DB)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .key_n         (key_n),
    .avs           (bus.slave),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: a key flips once its last DB synchronized samples all disagree with it.
  bit           hist [W][$];
  logic [W-1:0] m_s1 = '1, m_s2 = '1, m_deb = '0, m_prev = '0, m_mask = '0, m_edge = '0;
  logic [31:0]  m_rd = '0;

  always @(posedge clk or negedge rst_n) begin
    logic [W-1:0] n_deb, clr;
    logic [31:0]  rd;
    bit           all;
    if (!rst_n) begin
      m_s1 = '1; m_s2 = '1; m_deb = '0; m_prev = '0;
      m_mask = '0; m_edge = '0; m_rd = '0;
      for (int k = 0; k < W; k++) hist[k].delete();
    end else begin
      n_deb = m_deb;
      for (int k = 0; k < W; k++) begin
        hist[k].push_back(~m_s2[k]);
        if (hist[k].size() > DB) void'(hist[k].pop_front());
        if (hist[k].size() == DB) begin
          all = 1'b1;
          foreach (hist[k][j]) if (hist[k][j] == m_deb[k]) all = 1'b0;
          if (all) n_deb[k] = ~m_deb[k];
        end
      end
      rd = '0;
      case (bus.avs_address)
        2'd0: rd[W-1:0] = m_deb;
        2'd1: rd[W-1:0] = m_mask;
        2'd2: rd[W-1:0] = m_edge;
        default: rd = '0;
      endcase
      if (bus.avs_read) m_rd = rd;
      clr = (bus.avs_write && bus.avs_address == 2'd2) ? bus.avs_writedata[W-1:0] : '0;
      m_edge = (m_edge & ~clr) | (m_deb & ~m_prev);
      if (bus.avs_write && bus.avs_address == 2'd1) m_mask = bus.avs_writedata[W-1:0];
      m_prev = m_deb;
      m_deb  = n_deb;
      m_s2   = m_s1;
      m_s1   = key_n;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_rd", bus.avs_readdata, m_rd);
      chk("model_irq", {31'd0, irq}, {31'd0, |(m_edge & m_mask)});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    bus.avs_address = a; bus.avs_read = 1'b1;
    @(negedge clk);
    bus.avs_read = 1'b0;
    d = bus.avs_readdata;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] v);
    bus.avs_address = a; bus.avs_write = 1'b1; bus.avs_writedata = v;
    @(negedge clk);
    bus.avs_write = 1'b0;
  endtask

  logic [31:0] d;
  int          first, n;

  initial begin
    bus.avs_address = '0; bus.avs_read = 1'b0; bus.avs_write = 1'b0; bus.avs_writedata = '0;
    cyc(3);
    chk("rst_rd", bus.avs_readdata, 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'h0);
    chk_en = 1'b1;
    rst_n = 1'b1;
    cyc(2);

    // Stable press of key 0: DATA follows after 2 sync + DB debounce edges.
    key_n = 3'b110;
    first = 0;
    for (int i = 1; i <= 12; i++) begin
      bus_rd(2'd0, d);
      if (d[0] && first == 0) first = i;
    end
    chk("data_lat", first, 7);
    chk("data_val", d, 32'h1);
    bus_rd(2'd2, d); chk("edge_k0", d, 32'h1);
    chk("irq_masked", {31'd0, irq}, 32'h0);
    key_n = 3'b111; cyc(10);
    bus_wr(2'd2, 32'h7);
    bus_rd(2'd2, d); chk("edge_clr", d, 32'h0);

    // Short glitch on key 1 is rejected.
    key_n = 3'b101; cyc(3);
    key_n = 3'b111; cyc(10);
    bus_rd(2'd0, d); chk("glitch_data", d, 32'h0);
    bus_rd(2'd2, d); chk("glitch_edge", d, 32'h0);

    // MASK with junk in upper bits, then irq timing on key 2.
    bus_wr(2'd1, 32'hFFFF_FFFF);
    bus_rd(2'd1, d); chk("mask_rd", d, 32'h7);
    key_n = 3'b011;
    n = 0;
    while (!irq && n < 20) begin cyc(1); n++; end
    chk("irq_lat", n, 7);
    bus_rd(2'd2, d); chk("edge_k2", d, 32'h4);
    bus_wr(2'd2, 32'h4);
    chk("irq_fall", {31'd0, irq}, 32'h0);
    bus_rd(2'd2, d); chk("edge_k2_clr", d, 32'h0);

    // Clear aimed at the very edge that sets EDGE[0]: set wins.
    key_n = 3'b010; cyc(6);
    bus_wr(2'd2, 32'h1);
    bus_rd(2'd2, d); chk("set_wins", d, 32'h1);
    chk("set_wins_irq", {31'd0, irq}, 32'h1);

    // Press/release: release adds nothing, reads do not clear, addr 3 is zero.
    key_n = 3'b011; cyc(10);
    bus_wr(2'd2, 32'h7);
    key_n = 3'b010; cyc(10);
    key_n = 3'b011; cyc(10);
    bus_rd(2'd2, d); chk("edge_rd1", d, 32'h1);
    bus_rd(2'd2, d); chk("edge_rd2", d, 32'h1);
    bus_wr(2'd3, 32'hFFFF_FFFF);
    bus_rd(2'd3, d); chk("addr3", d, 32'h0);

    // Async reset with MASK=7, EDGE=5.
    key_n = 3'b111; cyc(10);
    key_n = 3'b010; cyc(10);
    bus_rd(2'd2, d); chk("edge_5", d, 32'h5);
    chk("irq_pre_rst", {31'd0, irq}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_irq", {31'd0, irq}, 32'h0);
    chk("async_rd", bus.avs_readdata, 32'h0);
    cyc(2);
    rst_n = 1'b1;
    bus_rd(2'd1, d); chk("rst_mask", d, 32'h0);
    bus_rd(2'd2, d); chk("rst_edge", d, 32'h0);
    cyc(8);
    bus_rd(2'd2, d); chk("held_thru_rst", d, 32'h5);

    // Reset mid-debounce abandons the count.
    key_n = 3'b111; cyc(10);
    bus_wr(2'd2, 32'h7);
    key_n = 3'b101; cyc(3);
    #2 rst_n = 1'b0;
    key_n = 3'b111;
    cyc(2);
    rst_n = 1'b1;
    cyc(10);
    bus_rd(2'd2, d); chk("mid_rst_edge", d, 32'h0);
    bus_rd(2'd0, d); chk("mid_rst_data", d, 32'h0);

    // Random traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) key_n[$urandom_range(W-1)] ^= 1'b1;
      bus.avs_address   = 2'($urandom_range(3));
      bus.avs_writedata = $urandom;
      case ($urandom_range(3))
        0: begin bus.avs_read = 1'b1; bus.avs_write = 1'b0; end
        1: begin bus.avs_read = 1'b0; bus.avs_write = ($urandom_range(3) == 0); end
        2: begin bus.avs_read = 1'b1; bus.avs_write = ($urandom_range(3) == 0); end
        default: begin bus.avs_read = 1'b0; bus.avs_write = 1'b0; end
      endcase
      if ($urandom_range(599) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    bus.avs_read = 1'b0; bus.avs_write = 1'b0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
